// File: rtl/fpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ctrl_pkg
//  Purpose  : Shared types and constants for the FPU job controller: the job
//             FSM state type, 64-bit CSR indices, the DFH constant and the
//             STATUS/CTRL bit positions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } t_job_state;

  // CSR indices (64-bit word index on the MMIO channel)
  localparam logic [7:0] c_IDX_DFH       = 8'h00;
  localparam logic [7:0] c_IDX_ID_L      = 8'h01;
  localparam logic [7:0] c_IDX_ID_H      = 8'h02;
  localparam logic [7:0] c_IDX_CTRL      = 8'h10;
  localparam logic [7:0] c_IDX_STATUS    = 8'h11;
  localparam logic [7:0] c_IDX_CFG_COUNT = 8'h12;
  localparam logic [7:0] c_IDX_CFG_BASE  = 8'h13;
  localparam logic [7:0] c_IDX_TIMEOUT   = 8'h14;
  localparam logic [7:0] c_IDX_CFG       = 8'h20;

  // Feature type AFU in [63:60], end-of-list flag in bit 40
  localparam logic [63:0] c_DFH = 64'h1000_0100_0000_0000;

  localparam int c_CFG_DATA_W = 32;

  // CTRL bits
  localparam int c_CTRL_START = 0;
  localparam int c_CTRL_ABORT = 1;

  // STATUS bits
  localparam int c_ST_BUSY    = 0;
  localparam int c_ST_DONE    = 1;
  localparam int c_ST_ERR     = 2;
  localparam int c_ST_TIMEOUT = 3;
  localparam int c_ST_CNT_LSB = 32;
  localparam int c_ST_CNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/fpu_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_cfg_regfile
//  Purpose  : Configuration word storage for the job sequencer.
//  Ports    : clk/rst      - clock, synchronous active-high reset (clears all)
//             i_wr_*       - single write port
//             i_seq_idx    - combinational read index for the sequencer
//             o_seq_data   - combinational read data
//             i_rd_idx     - MMIO read index, sampled every cycle
//             o_rd_data    - registered MMIO read data (old value on a
//                            same-cycle write to the same slot)
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_cfg_regfile
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [IW-1:0]           i_wr_idx,
  input  logic [c_CFG_DATA_W-1:0] i_wr_data,
  input  logic [IW-1:0]           i_seq_idx,
  output logic [c_CFG_DATA_W-1:0] o_seq_data,
  input  logic [IW-1:0]           i_rd_idx,
  output logic [c_CFG_DATA_W-1:0] o_rd_data
);

  logic [c_CFG_DATA_W-1:0] r_mem [DEPTH];
  logic [c_CFG_DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem     <= '{default: '0};
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[i_wr_idx] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_seq_data = r_mem[i_seq_idx];
  assign o_rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fpu_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_job_ctrl
//  Purpose  : Host CSR file and job sequencer for the FPU mapped-config port.
//             START streams CFG[0..N-1] to CFG_BASE+4*i, then a doorbell beat,
//             then waits for fpu_done (optionally bounded by TIMEOUT cycles).
//  Ports    : clk/rst            - clock, synchronous active-high reset
//             afu_id             - AFU UUID for the ID CSRs
//             mmio_wr_*          - host CSR write (64-bit word index)
//             mmio_rd_* / rsp_*  - host CSR read, response one cycle later
//             mapped_*           - FPU configuration beats, no backpressure
//             fpu_done           - single-cycle job-complete pulse
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_job_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned CFG_DEPTH    = 16,   // 2..31 (CFG_COUNT is 5 bits)
  parameter logic [31:0] DOORBELL_OFS = 32'h40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] afu_id,
  input  logic         mmio_wr_valid,
  input  logic [7:0]   mmio_wr_idx,
  input  logic [63:0]  mmio_wr_data,
  input  logic         mmio_rd_valid,
  input  logic [7:0]   mmio_rd_idx,
  input  logic [8:0]   mmio_rd_tid,
  output logic         mmio_rsp_valid,
  output logic [63:0]  mmio_rsp_data,
  output logic [8:0]   mmio_rsp_tid,
  output logic         mapped_data_valid,
  output logic [31:0]  mapped_address,
  output logic [31:0]  mapped_data,
  input  logic         fpu_done
);

  localparam int unsigned c_IW = $clog2(CFG_DEPTH);

  t_job_state  r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [31:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic        r_done, r_err, r_tmo;
  logic [15:0] r_job_cnt;
  logic [4:0]  r_cfg_count;
  logic [31:0] r_cfg_base;
  logic [31:0] r_tmo_val;
  logic        r_rsp_valid, r_rsp_is_cfg;
  logic [8:0]  r_rsp_tid;
  logic [63:0] r_rsp_data;

  logic        w_busy, w_ctrl_wr, w_start, w_abort, w_count_ok, w_doorbell;
  logic        w_set_done, w_set_err, w_set_tmo, w_clr_status;
  logic [7:0]  w_wr_off, w_rd_off;
  logic        w_wr_cfg_hit, w_rd_cfg_hit, w_cfg_wr_en;
  logic [31:0] w_seq_data, w_cfg_rd_q;
  logic [63:0] w_status, w_rd_data;
  logic        w_unused;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_ctrl_wr  = mmio_wr_valid && (mmio_wr_idx == c_IDX_CTRL);
  assign w_start    = w_ctrl_wr && mmio_wr_data[c_CTRL_START];
  assign w_abort    = w_ctrl_wr && mmio_wr_data[c_CTRL_ABORT];
  assign w_count_ok = (r_cfg_count != 5'd0) && (32'(r_cfg_count) <= CFG_DEPTH);
  // The cycle after the last config beat carries the doorbell.
  assign w_doorbell = (r_idx == r_cfg_count);

  // Indices below the CFG window wrap to >= 0xE0, so one compare covers both bounds.
  assign w_wr_off     = mmio_wr_idx - c_IDX_CFG;
  assign w_rd_off     = mmio_rd_idx - c_IDX_CFG;
  assign w_wr_cfg_hit = (32'(w_wr_off) < CFG_DEPTH);
  assign w_rd_cfg_hit = (32'(w_rd_off) < CFG_DEPTH);
  assign w_cfg_wr_en  = mmio_wr_valid && w_wr_cfg_hit && !w_busy;

  assign w_unused = ^mmio_wr_data[63:32];

  fpu_cfg_regfile #(
    .DEPTH (CFG_DEPTH),
    .IW    (c_IW)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_cfg_wr_en),
    .i_wr_idx   (w_wr_off[c_IW-1:0]),
    .i_wr_data  (mmio_wr_data[31:0]),
    .i_seq_idx  (r_idx[c_IW-1:0]),
    .o_seq_data (w_seq_data),
    .i_rd_idx   (w_rd_off[c_IW-1:0]),
    .o_rd_data  (w_cfg_rd_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_tmo_cnt_nxt     = '0;
    w_set_done        = 1'b0;
    w_set_err         = 1'b0;
    w_set_tmo         = 1'b0;
    w_clr_status      = 1'b0;
    mapped_data_valid = 1'b0;
    mapped_address    = '0;
    mapped_data       = '0;
    case (r_state)
      ST_IDLE: begin
        // ABORT alongside START cancels the START; ABORT alone does nothing here.
        if (w_start && !w_abort) begin
          if (w_count_ok) begin
            w_state_nxt  = ST_LOAD;
            w_idx_nxt    = '0;
            w_clr_status = 1'b1;
          end else begin
            w_set_err = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        mapped_data_valid = 1'b1;
        if (w_doorbell) begin
          mapped_address = r_cfg_base + DOORBELL_OFS;
          mapped_data    = 32'd1;
          w_state_nxt    = ST_WAIT;
        end else begin
          mapped_address = r_cfg_base + {25'd0, r_idx, 2'b00};
          mapped_data    = w_seq_data;
          w_idx_nxt      = r_idx + 5'd1;
        end
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_set_err   = 1'b1;
        end else if (w_start) begin
          w_set_err = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_set_err   = 1'b1;
        end else begin
          if (w_start) begin
            w_set_err = 1'b1;
          end
          // Completion beats a coincident timeout.
          if (fpu_done) begin
            w_state_nxt = ST_IDLE;
            w_set_done  = 1'b1;
          end else if ((r_tmo_val != 32'd0) && (r_tmo_cnt + 32'd1 >= r_tmo_val)) begin
            w_state_nxt = ST_IDLE;
            w_set_err   = 1'b1;
            w_set_tmo   = 1'b1;
          end else begin
            w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tmo       <= 1'b0;
      r_job_cnt   <= '0;
      r_cfg_count <= '0;
      r_cfg_base  <= '0;
      r_tmo_val   <= '0;
    end else begin
      if (w_clr_status) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_tmo  <= 1'b0;
      end
      if (w_set_done) begin
        r_done    <= 1'b1;
        r_job_cnt <= r_job_cnt + 16'd1;
      end
      if (w_set_err) r_err <= 1'b1;
      if (w_set_tmo) r_tmo <= 1'b1;
      if (mmio_wr_valid && !w_busy) begin
        if (mmio_wr_idx == c_IDX_CFG_COUNT) r_cfg_count <= mmio_wr_data[4:0];
        if (mmio_wr_idx == c_IDX_CFG_BASE)  r_cfg_base  <= mmio_wr_data[31:0];
      end
      if (mmio_wr_valid && (mmio_wr_idx == c_IDX_TIMEOUT)) begin
        r_tmo_val <= mmio_wr_data[31:0];
      end
    end
  end

  always_comb begin
    w_status                            = '0;
    w_status[c_ST_BUSY]                 = w_busy;
    w_status[c_ST_DONE]                 = r_done;
    w_status[c_ST_ERR]                  = r_err;
    w_status[c_ST_TIMEOUT]              = r_tmo;
    w_status[c_ST_CNT_LSB +: c_ST_CNT_W] = r_job_cnt;
  end

  always_comb begin
    w_rd_data = '0;
    case (mmio_rd_idx)
      c_IDX_DFH:       w_rd_data = c_DFH;
      c_IDX_ID_L:      w_rd_data = afu_id[63:0];
      c_IDX_ID_H:      w_rd_data = afu_id[127:64];
      c_IDX_STATUS:    w_rd_data = w_status;
      c_IDX_CFG_COUNT: w_rd_data = {59'd0, r_cfg_count};
      c_IDX_CFG_BASE:  w_rd_data = {32'd0, r_cfg_base};
      c_IDX_TIMEOUT:   w_rd_data = {32'd0, r_tmo_val};
      default:         w_rd_data = '0;
    endcase
  end

  // CFG reads take their data from the regfile's own registered port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_tid    <= '0;
      r_rsp_data   <= '0;
      r_rsp_is_cfg <= 1'b0;
    end else begin
      r_rsp_valid  <= mmio_rd_valid;
      r_rsp_tid    <= mmio_rd_valid ? mmio_rd_tid : 9'd0;
      r_rsp_data   <= (mmio_rd_valid && !w_rd_cfg_hit) ? w_rd_data : 64'd0;
      r_rsp_is_cfg <= mmio_rd_valid && w_rd_cfg_hit;
    end
  end

  assign mmio_rsp_valid = r_rsp_valid;
  assign mmio_rsp_tid   = r_rsp_tid;
  assign mmio_rsp_data  = r_rsp_is_cfg ? {32'd0, w_cfg_rd_q} : r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_fpu_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_job_ctrl
//  Purpose  : Scoreboard bench for fpu_job_ctrl. Stimulus pushes expected
//             read responses and config beats (with their cycle stamps);
//             a negedge monitor pops and compares whatever the DUT presents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_job_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] afu_id;
  logic         mmio_wr_valid;
  logic [7:0]   mmio_wr_idx;
  logic [63:0]  mmio_wr_data;
  logic         mmio_rd_valid;
  logic [7:0]   mmio_rd_idx;
  logic [8:0]   mmio_rd_tid;
  logic         mmio_rsp_valid;
  logic [63:0]  mmio_rsp_data;
  logic [8:0]   mmio_rsp_tid;
  logic         mapped_data_valid;
  logic [31:0]  mapped_address;
  logic [31:0]  mapped_data;
  logic         fpu_done;

  fpu_job_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .afu_id            (afu_id),
    .mmio_wr_valid     (mmio_wr_valid),
    .mmio_wr_idx       (mmio_wr_idx),
    .mmio_wr_data      (mmio_wr_data),
    .mmio_rd_valid     (mmio_rd_valid),
    .mmio_rd_idx       (mmio_rd_idx),
    .mmio_rd_tid       (mmio_rd_tid),
    .mmio_rsp_valid    (mmio_rsp_valid),
    .mmio_rsp_data     (mmio_rsp_data),
    .mmio_rsp_tid      (mmio_rsp_tid),
    .mapped_data_valid (mapped_data_valid),
    .mapped_address    (mapped_address),
    .mapped_data       (mapped_data),
    .fpu_done          (fpu_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [8:0] tid; logic [63:0] data; int cyc; } t_rd_exp;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } t_beat_exp;

  t_rd_exp     q_rd[$];
  t_beat_exp   q_beat[$];
  int          checks   = 0;
  int          failures = 0;
  logic [8:0]  tid_n    = 9'h1A0;
  logic [31:0] m_cfg [16];
  logic [31:0] m_base;

  localparam logic [31:0] c_A = 32'hA5A5_0001;
  localparam logic [31:0] c_B = 32'h5A5A_0002;
  localparam logic [31:0] c_C = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented response or beat must match the queue head, on time.
  always @(negedge clk) begin
    t_rd_exp   e_rd;
    t_beat_exp e_bt;
    if (mmio_rsp_valid === 1'b1) begin
      chk("rsp_expected", 64'(q_rd.size() > 0), 64'd1);
      if (q_rd.size() > 0) begin
        e_rd = q_rd.pop_front();
        chk("rsp_tid", 64'(mmio_rsp_tid), 64'(e_rd.tid));
        chk("rsp_data", mmio_rsp_data, e_rd.data);
        chk("rsp_cycle", 64'(cyc), 64'(e_rd.cyc));
      end
    end
    if (mapped_data_valid === 1'b1) begin
      chk("beat_expected", 64'(q_beat.size() > 0), 64'd1);
      if (q_beat.size() > 0) begin
        e_bt = q_beat.pop_front();
        chk("beat_addr", 64'(mapped_address), 64'(e_bt.addr));
        chk("beat_data", 64'(mapped_data), 64'(e_bt.data));
        chk("beat_cycle", 64'(cyc), 64'(e_bt.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wr(input logic [7:0] idx, input logic [63:0] d);
    mmio_wr_valid = 1'b1;
    mmio_wr_idx   = idx;
    mmio_wr_data  = d;
    tick();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] idx, input logic [63:0] exp);
    t_rd_exp e;
    mmio_rd_valid = 1'b1;
    mmio_rd_idx   = idx;
    mmio_rd_tid   = tid_n;
    e.tid  = tid_n;
    e.data = exp;
    e.cyc  = cyc + 1;
    q_rd.push_back(e);
    tid_n = tid_n + 9'd7;
    tick();
    mmio_rd_valid = 1'b0;
  endtask

  task automatic rw_same(input logic [7:0] idx, input logic [63:0] d, input logic [63:0] exp);
    mmio_wr_valid = 1'b1;
    mmio_wr_idx   = idx;
    mmio_wr_data  = d;
    rd(idx, exp);
    mmio_wr_valid = 1'b0;
  endtask

  task automatic wr_cfg(input logic [3:0] i, input logic [31:0] d);
    wr(8'h20 + {4'd0, i}, {32'hBAD0_0000, d});
    m_cfg[i] = d;
  endtask

  task automatic pulse_done();
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
  endtask

  // Issues START now (cycle t) and queues nb config beats plus optional doorbell.
  task automatic start_job(input int nb, input bit db, output int t);
    t_beat_exp b;
    t = cyc;
    for (int k = 0; k < nb; k++) begin
      b.addr = m_base + 32'(k * 4);
      b.data = m_cfg[k[3:0]];
      b.cyc  = t + 1 + k;
      q_beat.push_back(b);
    end
    if (db) begin
      b.addr = m_base + 32'h40;
      b.data = 32'd1;
      b.cyc  = t + 1 + nb;
      q_beat.push_back(b);
    end
    wr(8'h10, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst           = 1'b1;
    afu_id        = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    mmio_wr_valid = 1'b0;
    mmio_wr_idx   = '0;
    mmio_wr_data  = '0;
    mmio_rd_valid = 1'b0;
    mmio_rd_idx   = '0;
    mmio_rd_tid   = '0;
    fpu_done      = 1'b0;
    m_cfg         = '{default: '0};
    m_base        = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("reset_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
    chk("reset_rsp_data", mmio_rsp_data, 64'd0);
    chk("reset_rsp_tid", 64'(mmio_rsp_tid), 64'd0);
    chk("reset_beat_valid", 64'(mapped_data_valid), 64'd0);
    chk("reset_beat_addr", 64'(mapped_address), 64'd0);
    chk("reset_beat_data", 64'(mapped_data), 64'd0);

    // ID CSRs, reset STATUS, write-only and unmapped indices
    rd(8'h00, 64'h1000_0100_0000_0000);
    rd(8'h01, 64'hFEDC_BA98_7654_3210);
    rd(8'h02, 64'h0123_4567_89AB_CDEF);
    rd(8'h11, 64'd0);
    rd(8'h10, 64'd0);
    wr(8'h30, '1);
    wr(8'h05, '1);
    rd(8'h30, 64'd0);
    rd(8'h05, 64'd0);
    rd(8'h14, 64'd0);

    // Job configuration with junk upper bits
    wr(8'h13, 64'hDEAD_BEEF_0000_1000);
    m_base = 32'h1000;
    wr(8'h12, 64'hE3);
    rd(8'h12, 64'd3);
    wr_cfg(4'd0, c_A);
    wr_cfg(4'd1, c_B);
    wr_cfg(4'd2, c_C);
    rd(8'h20, {32'd0, c_A});
    rd(8'h13, 64'h1000);
    rd(8'h22, {32'd0, c_C});

    // Normal job: beats T+1..T+4, done pulse at T+6
    start_job(3, 1'b1, t);
    rd(8'h11, 64'h0000_0000_0000_0001);
    wait_until(t + 6);
    pulse_done();
    rd(8'h11, 64'h0000_0001_0000_0002);

    // Same-cycle write and read returns the old value
    rw_same(8'h13, 64'h2000, 64'h1000);
    m_base = 32'h2000;
    rd(8'h13, 64'h2000);

    // CFG_COUNT=0 START: err only, done preserved
    wr(8'h12, 64'd0);
    start_job(0, 1'b0, t);
    rd(8'h11, 64'h0000_0001_0000_0006);

    // fpu_done while idle is ignored
    pulse_done();
    rd(8'h11, 64'h0000_0001_0000_0006);

    // Timeout after exactly 5 WAIT cycles (WAIT = T+3..T+7)
    wr(8'h12, 64'd1);
    wr(8'h14, 64'd5);
    start_job(1, 1'b1, t);
    wait_until(t + 7);
    rd(8'h11, 64'h0000_0001_0000_0001);
    rd(8'h11, 64'h0000_0001_0000_000C);

    // fpu_done in the timeout cycle wins
    start_job(1, 1'b1, t);
    wait_until(t + 7);
    pulse_done();
    rd(8'h11, 64'h0000_0002_0000_0002);

    // ABORT mid-LOAD with 16 slots; CFG write and START during LOAD ignored
    wr(8'h14, 64'd0);
    wr(8'h12, 64'd16);
    start_job(3, 1'b0, t);
    wr(8'h20, 64'h55);
    wr(8'h10, 64'h1);
    wr(8'h10, 64'h2);
    rd(8'h11, 64'h0000_0002_0000_0004);
    rd(8'h20, {32'd0, c_A});

    // START+ABORT together in IDLE: nothing happens
    wr(8'h10, 64'h3);
    rd(8'h11, 64'h0000_0002_0000_0004);

    // START while in WAIT sets err, job still completes
    wr(8'h12, 64'd1);
    start_job(1, 1'b1, t);
    wait_until(t + 3);
    wr(8'h10, 64'h1);
    rd(8'h11, 64'h0000_0002_0000_0005);
    pulse_done();
    rd(8'h11, 64'h0000_0003_0000_0006);

    // Address wrap modulo 2^32
    wr(8'h13, 64'hFFFF_FFF8);
    m_base = 32'hFFFF_FFF8;
    wr(8'h12, 64'd3);
    start_job(3, 1'b1, t);
    wait_until(t + 5);
    pulse_done();
    rd(8'h11, 64'h0000_0004_0000_0002);

    // Reset during LOAD: one beat, then everything cleared
    wr(8'h13, 64'h3000);
    m_base = 32'h3000;
    wr(8'h12, 64'd16);
    start_job(1, 1'b0, t);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_beat_valid", 64'(mapped_data_valid), 64'd0);
    chk("rst_mid_beat_addr", 64'(mapped_address), 64'd0);
    rd(8'h11, 64'd0);
    rd(8'h20, 64'd0);
    rd(8'h13, 64'd0);
    rd(8'h12, 64'd0);

    repeat (5) tick();
    chk("rd_queue_empty", 64'(q_rd.size()), 64'd0);
    chk("beat_queue_empty", 64'(q_beat.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_job_ctrl.md
# fpu_job_ctrl

Job sequencer between the host MMIO path and the FPU's mapped-configuration port. It holds a host-visible CSR file, including DFH, AFU ID, control, status and up to 16 configuration words. On a host START it streams the configuration words into the FPU as `mapped_address`/`mapped_data` beats, waits for FPU completion with an optional timeout, and reports status. It sits in `afu` between the decoded CCI-P MMIO channel and the `FPU` instance.

## Interface
Parameters:
- `CFG_DEPTH`, 16: number of 32-bit configuration slots.
- `DOORBELL_OFS`, 32'h40: offset from CFG_BASE of the final "go" beat.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `afu_id`  in  128  AFU UUID returned by the ID CSRs.
- `mmio_wr_valid`  in  1  host CSR write strobe.
- `mmio_wr_idx`  in  8  64-bit CSR index.
- `mmio_wr_data`  in  64  write data.
- `mmio_rd_valid`  in  1  host CSR read request.
- `mmio_rd_idx`  in  8  CSR index.
- `mmio_rd_tid`  in  9  CCI-P transaction ID.
- `mmio_rsp_valid`  out  1  read response strobe.
- `mmio_rsp_data`  out  64  read data.
- `mmio_rsp_tid`  out  9  echoed tid.
- `mapped_data_valid`  out  1  FPU config beat valid.
- `mapped_address`  out  32  FPU config address.
- `mapped_data`  out  32  FPU config data.
- `fpu_done`  in  1  single-cycle FPU job-complete pulse.

## Operation
CSR map (index: access, contents):
- 0x00 RO DFH constant (type AFU, EOL=1); 0x01 RO afu_id[63:0]; 0x02 RO afu_id[127:64]; 0x03–0x0F RO 0.
- 0x10 CTRL, write-only (reads 0): bit0 START, bit1 ABORT.
- 0x11 STATUS RO: bit0 busy, bit1 done, bit2 err, bit3 timeout, [47:32] completed-job count (wraps at 16 bits).
- 0x12 CFG_COUNT RW [4:0], valid range 1..CFG_DEPTH. 0x13 CFG_BASE RW [31:0]. 0x14 TIMEOUT RW [31:0] cycles; 0 means no timeout.
- 0x20–0x2F CFG[i] RW [31:0]. Upper bits read 0. Unmapped indices read 0; writes to them are dropped.

FSM states and transitions:
- IDLE → LOAD on START when CFG_COUNT is in 1..CFG_DEPTH. This clears done/err/timeout and sets i=0.
- START with CFG_COUNT=0 or >CFG_DEPTH: stay in IDLE, set err.
- LOAD: each cycle emit address = CFG_BASE + 4*i, data = CFG[i], i++. After beat CFG_COUNT-1, emit one doorbell beat (address = CFG_BASE + DOORBELL_OFS, data = 1), then go to WAIT.
- WAIT → IDLE on `fpu_done`: set done, count++. The timeout counter runs only in WAIT. When it reaches TIMEOUT (if nonzero), go to IDLE and set err and timeout.
- ABORT in LOAD/WAIT → IDLE with err set and no done. ABORT in IDLE: no effect.
- START while busy: ignored, err set. START and ABORT in the same write: ABORT wins.
- Writes to CFG_COUNT, CFG_BASE and CFG[] while busy are dropped. TIMEOUT is writable at any time.
- `fpu_done` outside WAIT is ignored.
- Address arithmetic wraps modulo 2^32.

## Timing
- Reset values: all outputs 0, state IDLE, all CSRs 0, count 0.
- Read response: exactly 1 cycle after `mmio_rd_valid`. Responses are in order, one per cycle, with tid echoed. A same-cycle read and write to one CSR returns the old value.
- A START write at cycle T gives the first beat at T+1. Config beats occupy T+1..T+N, the doorbell is at T+N+1, and WAIT begins at T+N+2. busy reads 1 from T+1.
- Beats are back-to-back with no backpressure. `mapped_data_valid` is low in every non-LOAD cycle.
- `fpu_done` at cycle D: IDLE at D+1, and a read issued at D+1 sees done=1.
- ABORT at cycle A: no beat at A+1 or later.
- Timeout: asserts after exactly TIMEOUT cycles in WAIT. `fpu_done` in the same cycle as the timeout wins (done, no err).
- Reset mid-job: the next cycle is IDLE, outputs are 0 and CSRs are cleared.

## Structure
- Package `fpu_ctrl_pkg`: state enum `t_job_state`, CSR index localparams, DFH constant, STATUS bit positions.
- One sub-module, `fpu_cfg_regfile`: CFG_DEPTH×32 storage with a write port, a combinational read port for the sequencer and a registered read port for MMIO.
- FSM, timeout counter and the MMIO response register live in `fpu_job_ctrl`.

## Test plan
- Reset, then read 0x00/0x01/0x02: the DFH constant and afu_id halves are returned 1 cycle later with the tids echoed. STATUS reads 0.
- CFG_BASE=0x1000, CFG_COUNT=3, CFG[0..2]=A,B,C, START at T: beats (0x1000,A),(0x1004,B),(0x1008,C),(0x1040,1) at T+1..T+4. `fpu_done` pulse gives STATUS=done, count=1.
- CFG_COUNT=0 then START: no beats, STATUS.err=1, busy=0.
- TIMEOUT=5, job with no `fpu_done`: IDLE after 5 WAIT cycles, STATUS err=1 and timeout=1.
- ABORT mid-LOAD with CFG_COUNT=16: beats stop the next cycle, err=1. A CFG[0] write during LOAD is dropped (readback unchanged).
- START while busy and `fpu_done` while IDLE: both are ignored except that the START sets err. Count wraps 0xFFFF→0 after 65536 jobs (count forced via force or shortened param).
